armv8_multicycle_ctrl: RTL

Multi-cycle main control FSM for the ARMv8 (LEGv8 subset) datapath. It sequences fetch, decode, execute, memory and write-back. It drives the datapath selects, including reg2loc for the register-file read-address mux (0 = rm, 1 = rt), and all write enables. It sits between the instruction register and the datapath, handshaking with instruction and data memory.

---
 rtl/armv8_multicycle_ctrl_pkg.sv | 35 +++
 rtl/armv8_opcode_decode.sv | 24 ++
 rtl/armv8_multicycle_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/armv8_multicycle_ctrl_pkg.sv
// rtl/armv8_multicycle_ctrl_pkg.sv - shared encodings for the LEGv8 multi-cycle control FSM
// Contents: state encodings, opcode constants, aluop encodings, instruction-class enum.
package armv8_multicycle_ctrl_pkg;

  // FSM state encodings (3-bit, codes 5..7 unused)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // Opcode field instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ only fixes the upper 8 opcode bits
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  // ALU control to the ALU-control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RFMT  = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_RFMT = 3'd1,
    CLS_LDUR = 3'd2,
    CLS_STUR = 3'd3,
    CLS_CBZ  = 3'd4
  } instr_cls_e;

endpackage

// File: rtl/armv8_opcode_decode.sv
// rtl/armv8_opcode_decode.sv - combinational opcode classifier
// Ports: i_opcode (instr[31:21]) in; o_cls instruction class, o_illegal unrecognised opcode.
module armv8_opcode_decode
  import armv8_multicycle_ctrl_pkg::*;
(
  input  logic [10:0] i_opcode,
  output instr_cls_e  o_cls,
  output logic        o_illegal
);

  always_comb begin
    o_cls = CLS_NONE;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: o_cls = CLS_RFMT;
      OP_LDUR:                        o_cls = CLS_LDUR;
      OP_STUR:                        o_cls = CLS_STUR;
      default: begin
        if (i_opcode[10:3] == OP_CBZ_HI) o_cls = CLS_CBZ;
      end
    endcase
    o_illegal = (o_cls == CLS_NONE);
  end

endmodule

// File: rtl/armv8_multicycle_ctrl.sv
// rtl/armv8_multicycle_ctrl.sv - multi-cycle main control FSM for the LEGv8 datapath
// Inputs: clk, rst_n (async active-low), opcode, instr_valid, mem_ready, zero.
// Outputs (all registered): reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, aluop,
//   ir_write, pc_write, pc_src, done, illegal, bus_err, state.
// Level outputs of a state (strobes, selects, regwrite) are computed from the next state so
// they are high while the FSM sits in that state. Outputs that depend on an input sampled in
// a state (fetch handshake, CBZ branch, STUR completion, illegal, bus_err) appear in the
// cycle after that state.
module armv8_multicycle_ctrl
  import armv8_multicycle_ctrl_pkg::*;
#(
  parameter int OPC_W       = 11,
  parameter int MEM_TIMEOUT = 15,
  parameter int ST_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic [1:0]       aluop,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             done,
  output logic             illegal,
  output logic             bus_err,
  output logic [ST_W-1:0]  state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_cnt;
  instr_cls_e       r_cls;
  logic             r_reg2loc, r_alusrc, r_memtoreg, r_regwrite, r_memread, r_memwrite;
  logic [1:0]       r_aluop;
  logic             r_ir_write, r_pc_write, r_pc_src, r_done, r_illegal, r_bus_err;

  instr_cls_e       w_dec_cls;
  logic             w_dec_illegal;
  instr_cls_e       w_cls;
  logic [ST_W-1:0]  w_next;
  logic             w_fetch_acc, w_timeout, w_cbz_taken, w_in_instr;

  armv8_opcode_decode u_decode (
    .i_opcode  (opcode),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal)
  );

  // In DECODE the class comes straight from the decoder; afterwards from the latched copy.
  assign w_cls = (r_state == S_DECODE) ? w_dec_cls : r_cls;

  always_comb begin
    w_next      = S_FETCH;
    w_fetch_acc = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_FETCH: begin
        // A taken branch updates PC during this FETCH cycle, so the fetch waits one cycle.
        if (instr_valid && !r_pc_write) begin
          w_fetch_acc = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: w_next = w_dec_illegal ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (w_cls == CLS_RFMT)                           w_next = S_WB;
        else if (w_cls == CLS_LDUR || w_cls == CLS_STUR) w_next = S_MEM;
      end
      S_MEM: begin
        // mem_ready takes priority over the timeout in the same cycle
        if (mem_ready)                                 w_next = (w_cls == CLS_LDUR) ? S_WB : S_FETCH;
        else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1))     w_timeout = 1'b1;
        else                                           w_next = S_MEM;
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_cbz_taken = (r_state == S_EXEC) && (w_cls == CLS_CBZ) && zero;
  assign w_in_instr  = (w_next == S_EXEC) || (w_next == S_MEM) || (w_next == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_cls      <= CLS_NONE;
      r_reg2loc  <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_aluop    <= ALUOP_ADD;
      r_ir_write <= 1'b0;
      r_pc_write <= 1'b0;
      r_pc_src   <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_MEM && w_next == S_MEM) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;

      r_ir_write <= w_fetch_acc;
      r_pc_write <= w_fetch_acc || w_cbz_taken;
      r_pc_src   <= w_cbz_taken;

      r_reg2loc  <= w_in_instr && (w_cls == CLS_STUR || w_cls == CLS_CBZ);
      r_alusrc   <= (w_next == S_EXEC) && (w_cls == CLS_LDUR || w_cls == CLS_STUR);
      if (w_next == S_EXEC) begin
        case (w_cls)
          CLS_RFMT: r_aluop <= ALUOP_RFMT;
          CLS_CBZ:  r_aluop <= ALUOP_PASSB;
          default:  r_aluop <= ALUOP_ADD;
        endcase
      end else begin
        r_aluop <= ALUOP_ADD;
      end

      r_memread  <= (w_next == S_MEM) && (w_cls == CLS_LDUR);
      r_memwrite <= (w_next == S_MEM) && (w_cls == CLS_STUR);
      r_regwrite <= (w_next == S_WB);
      r_memtoreg <= (w_next == S_WB) && (w_cls == CLS_LDUR);

      r_done    <= (w_next == S_WB)
                || ((r_state == S_EXEC) && (w_cls == CLS_CBZ))
                || ((r_state == S_MEM) && (w_cls == CLS_STUR) && mem_ready);
      r_illegal <= (r_state == S_DECODE) && w_dec_illegal;
      r_bus_err <= w_timeout;
    end
  end

  assign state    = r_state;
  assign reg2loc  = r_reg2loc;
  assign alusrc   = r_alusrc;
  assign memtoreg = r_memtoreg;
  assign regwrite = r_regwrite;
  assign memread  = r_memread;
  assign memwrite = r_memwrite;
  assign aluop    = r_aluop;
  assign ir_write = r_ir_write;
  assign pc_write = r_pc_write;
  assign pc_src   = r_pc_src;
  assign done     = r_done;
  assign illegal  = r_illegal;
  assign bus_err  = r_bus_err;

endmodule
